// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART motor-command receiver: parity modes,
// receiver FSM states and the ASCII command characters.
package uart_cmd_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_9 = 8'h39;
  localparam logic [7:0] ASC_R = 8'h52;
  localparam logic [7:0] ASC_r = 8'h72;
  localparam logic [7:0] ASC_L = 8'h4C;
  localparam logic [7:0] ASC_l = 8'h6C;

endpackage

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-flop synchroniser, tick divider, framing FSM,
// 3-sample majority vote per bit, and parity/framing error pulses.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = PAR_NONE
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DW  = $clog2(DIV);
  localparam int unsigned PW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  localparam logic [PW-1:0] PH_LO  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_MID = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_HI  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_rx_core: CLK_HZ/(BAUD*OVERSAMPLE) must be >= 2");
    end
  endgenerate

  rx_state_t state, state_n;

  logic [1:0]           rx_sync;
  logic                 rx_s, rx_prev;
  logic [DW-1:0]        div_cnt;
  logic [PW-1:0]        ph;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           samp;
  logic                 par_bad;
  logic                 tick, start_edge, at_lo, at_mid, at_hi, at_end, maj;
  logic                 rv_n, fe_n, pe_n;

  assign rx_s       = rx_sync[1];
  assign tick       = (div_cnt == DW'(DIV - 1));
  assign start_edge = (state == S_IDLE) && rx_prev && !rx_s;
  assign at_lo      = tick && (ph == PH_LO);
  assign at_mid     = tick && (ph == PH_MID);
  assign at_hi      = tick && (ph == PH_HI);
  assign at_end     = tick && (ph == PH_END);
  assign maj        = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

  always_ff @(posedge clk100) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // START holds until the end of the start-bit cell so every later cell's
  // phase counter begins at the bit boundary and the samples land mid-bit.
  always_comb begin
    state_n = state;
    rv_n    = 1'b0;
    fe_n    = 1'b0;
    pe_n    = 1'b0;
    case (state)
      S_IDLE:   if (start_edge) state_n = S_START;
      S_START:  begin
        if (at_mid && rx_s) state_n = S_IDLE;
        else if (at_end)    state_n = S_DATA;
      end
      S_DATA:   if (at_end && bit_cnt == BW'(DATA_BITS))
                  state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (at_end) state_n = S_STOP;
      S_STOP:   if (at_mid) begin
        if (!rx_s) begin
          fe_n    = 1'b1;
          state_n = S_BREAK;
        end else begin
          pe_n    = par_bad;
          rv_n    = !par_bad;
          state_n = S_IDLE;
        end
      end
      S_BREAK:  if (rx_s) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      rx_sync    <= '1;
      rx_prev    <= 1'b1;
      div_cnt    <= '0;
      ph         <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      samp       <= '0;
      par_bad    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], rx};
      rx_prev    <= rx_s;
      rx_valid   <= rv_n;
      frame_err  <= fe_n;
      parity_err <= pe_n;
      if (rv_n) rx_data <= shreg;
      if (start_edge) begin
        div_cnt <= '0;
        ph      <= '0;
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick)  ph <= (ph == PH_END) ? '0 : ph + 1'b1;
        if (at_lo) samp[0] <= rx_s;
        if (at_mid) samp[1] <= rx_s;
        if (at_hi && state == S_DATA) begin
          shreg   <= {maj, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (at_hi && state == S_PARITY)
          par_bad <= ((^shreg) ^ maj) != (PARITY == PAR_ODD);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART receiver plus registered ASCII motor-command decoder: digits set the
// speed (saturating), R/r and L/l set the turn direction.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = PAR_NONE,
  parameter int unsigned SPEED_W    = 4
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [SPEED_W-1:0]   speed,
  output logic                 turn,
  output logic                 cmd_valid,
  output logic                 cmd_err
);

  logic [DATA_BITS-1:0] core_data;
  logic                 core_valid;

  uart_rx_core #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS),
    .PARITY    (PARITY)
  ) u_core (
    .clk100    (clk100),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (core_data),
    .rx_valid  (core_valid),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  assign rx_data  = core_data;
  assign rx_valid = core_valid;

  generate
    if (DATA_BITS >= 7) begin : g_dec
      localparam int unsigned SMAX = (1 << SPEED_W) - 1;

      logic [7:0]         b;
      logic               is_digit;
      int unsigned        digit;
      logic [SPEED_W-1:0] dsat;

      always_comb begin
        b        = 8'(core_data);
        is_digit = (b >= ASC_0) && (b <= ASC_9);
        digit    = 32'(b - ASC_0);
        dsat     = (digit > SMAX) ? SPEED_W'(SMAX) : SPEED_W'(digit);
      end

      always_ff @(posedge clk100) begin
        if (reset) begin
          speed     <= '0;
          turn      <= 1'b0;
          cmd_valid <= 1'b0;
          cmd_err   <= 1'b0;
        end else begin
          cmd_valid <= 1'b0;
          cmd_err   <= 1'b0;
          if (core_valid) begin
            if (is_digit) begin
              speed     <= dsat;
              cmd_valid <= 1'b1;
            end else if (b == ASC_R || b == ASC_r) begin
              turn      <= 1'b1;
              cmd_valid <= 1'b1;
            end else if (b == ASC_L || b == ASC_l) begin
              turn      <= 1'b0;
              cmd_valid <= 1'b1;
            end else begin
              cmd_err   <= 1'b1;
            end
          end
        end
      end
    end else begin : g_nodec
      assign speed     = '0;
      assign turn      = 1'b0;
      assign cmd_valid = 1'b0;
      assign cmd_err   = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: three instances (defaults, SPEED_W=2, even parity)
// driven with directed and random frames, checked against a byte-level model.
module tb_uart_cmd_rx;

  localparam int BITC_DEF  = 864; // 100 MHz / 115200 / 16 = 54 -> 54*16
  localparam int BITC_FAST = 64;  // 100 MHz / 1.5625 MHz / 16 = 4 -> 4*16

  logic       clk100 = 1'b0;
  logic       reset  = 1'b1;
  logic       rxl  [3];
  logic [7:0] rdat [3];
  logic       rv [3], fe [3], pe [3], trn [3], cv [3], ce [3];
  logic [3:0] spd0, spd2;
  logic [1:0] spd1;

  always #5 clk100 = ~clk100;

  uart_cmd_rx u_def (
    .clk100(clk100), .reset(reset), .rx(rxl[0]), .rx_data(rdat[0]), .rx_valid(rv[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .speed(spd0), .turn(trn[0]),
    .cmd_valid(cv[0]), .cmd_err(ce[0])
  );

  uart_cmd_rx #(.BAUD(1_562_500), .SPEED_W(2)) u_s2 (
    .clk100(clk100), .reset(reset), .rx(rxl[1]), .rx_data(rdat[1]), .rx_valid(rv[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .speed(spd1), .turn(trn[1]),
    .cmd_valid(cv[1]), .cmd_err(ce[1])
  );

  uart_cmd_rx #(.BAUD(1_562_500), .PARITY(2)) u_par (
    .clk100(clk100), .reset(reset), .rx(rxl[2]), .rx_data(rdat[2]), .rx_valid(rv[2]),
    .frame_err(fe[2]), .parity_err(pe[2]), .speed(spd2), .turn(trn[2]),
    .cmd_valid(cv[2]), .cmd_err(ce[2])
  );

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, overlap = 0, bad_lat = 0, rv_cyc0 = 0, cv_cyc0 = 0;
  int   rv_n [3], fe_n [3], pe_n [3], cv_n [3], ce_n [3];
  logic rv_d [3];
  logic turn_log [$];

  logic [7:0] exp_data  [3];
  int         exp_speed [3];
  logic       exp_turn  [3];

  logic [7:0] pool [14] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                            8'h37, 8'h38, 8'h39, 8'h52, 8'h72, 8'h4C, 8'h6C};

  always @(posedge clk100) cyc <= cyc + 1;

  always @(negedge clk100) begin
    for (int i = 0; i < 3; i++) begin
      if (rv[i] === 1'b1) rv_n[i]++;
      if (fe[i] === 1'b1) fe_n[i]++;
      if (pe[i] === 1'b1) pe_n[i]++;
      if (cv[i] === 1'b1) cv_n[i]++;
      if (ce[i] === 1'b1) ce_n[i]++;
      if (int'(rv[i]) + int'(fe[i]) + int'(pe[i]) > 1) overlap++;
      if (cv[i] === 1'b1 && ce[i] === 1'b1) overlap++;
      if ((cv[i] === 1'b1 || ce[i] === 1'b1) && rv_d[i] !== 1'b1) bad_lat++;
      rv_d[i] = rv[i];
    end
    if (rv[0] === 1'b1) rv_cyc0 = cyc;
    if (cv[0] === 1'b1) begin
      cv_cyc0 = cyc;
      turn_log.push_back(trn[0]);
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] spd_of(input int inst);
    case (inst)
      0:       return 32'(spd0);
      1:       return 32'(spd1);
      default: return 32'(spd2);
    endcase
  endfunction

  function automatic logic [7:0] rnd_byte();
    if ($urandom_range(0, 1) == 1) return pool[$urandom_range(0, 13)];
    return 8'($urandom);
  endfunction

  // Byte-level model of the receiver + decoder outcome for one frame.
  function automatic void model(input int inst, input logic [7:0] b, input bit bad,
                                output int er, output int ep, output int ec, output int ee);
    int smax;
    int d;
    smax = (inst == 1) ? 3 : 15;
    er = 0; ep = 0; ec = 0; ee = 0;
    if (bad) begin
      ep = 1;
      return;
    end
    er = 1;
    exp_data[inst] = b;
    if (b >= 8'h30 && b <= 8'h39) begin
      d = int'(b) - 48;
      exp_speed[inst] = (d > smax) ? smax : d;
      ec = 1;
    end else if (b == 8'h52 || b == 8'h72) begin
      exp_turn[inst] = 1'b1;
      ec = 1;
    end else if (b == 8'h4C || b == 8'h6C) begin
      exp_turn[inst] = 1'b0;
      ec = 1;
    end else begin
      ee = 1;
    end
  endfunction

  task automatic drive_bit(input int inst, input logic v, input int bc);
    rxl[inst] = v;
    tick_wait(bc);
  endtask

  task automatic send(input int inst, input logic [7:0] b, input int bc,
                      input bit par, input bit bad_par, input bit stop_v);
    drive_bit(inst, 1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(inst, b[i], bc);
    if (par) drive_bit(inst, (^b) ^ bad_par, bc);
    drive_bit(inst, stop_v, bc);
    if (stop_v) rxl[inst] = 1'b1;
  endtask

  task automatic frame_check(input int inst, input logic [7:0] b, input int bc,
                             input bit par, input bit bad, input string tag);
    int r0, p0, f0, c0, e0, er, ep, ec, ee;
    r0 = rv_n[inst]; p0 = pe_n[inst]; f0 = fe_n[inst]; c0 = cv_n[inst]; e0 = ce_n[inst];
    send(inst, b, bc, par, bad, 1'b1);
    tick_wait(4);
    model(inst, b, bad, er, ep, ec, ee);
    chk({tag, "_rx_valid"},   32'(rv_n[inst] - r0), 32'(er));
    chk({tag, "_parity_err"}, 32'(pe_n[inst] - p0), 32'(ep));
    chk({tag, "_frame_err"},  32'(fe_n[inst] - f0), 32'd0);
    chk({tag, "_cmd_valid"},  32'(cv_n[inst] - c0), 32'(ec));
    chk({tag, "_cmd_err"},    32'(ce_n[inst] - e0), 32'(ee));
    chk({tag, "_rx_data"},    32'(rdat[inst]), 32'(exp_data[inst]));
    chk({tag, "_speed"},      spd_of(inst), 32'(exp_speed[inst]));
    chk({tag, "_turn"},       32'(trn[inst]), 32'(exp_turn[inst]));
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_data"},  32'(rdat[i]), 32'd0);
      chk({tag, "_speed"}, spd_of(i), 32'd0);
      chk({tag, "_flags"}, 32'({rv[i], fe[i], pe[i], cv[i], ce[i], trn[i]}), 32'd0);
    end
  endtask

  initial begin
    int s0, r0, c0, e0, ls;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      rxl[i] = 1'b1; exp_data[i] = '0; exp_speed[i] = 0; exp_turn[i] = 1'b0;
    end
    reset = 1'b1;
    tick_wait(5);
    reset = 1'b0;
    tick_wait(2);
    check_zero("reset");

    // Default 115200 8N1: '5' and decoder one cycle behind rx_valid
    frame_check(0, 8'h35, BITC_DEF, 1'b0, 1'b0, "def5");
    chk("def5_latency", 32'(cv_cyc0 - rv_cyc0), 32'd1);

    // 'R' then 'L' with no idle gap
    r0 = rv_n[0]; c0 = cv_n[0]; e0 = ce_n[0] + fe_n[0] + pe_n[0]; ls = turn_log.size();
    send(0, 8'h52, BITC_DEF, 1'b0, 1'b0, 1'b1);
    send(0, 8'h4C, BITC_DEF, 1'b0, 1'b0, 1'b1);
    tick_wait(4);
    exp_data[0] = 8'h4C; exp_turn[0] = 1'b0;
    chk("b2b_rx_valid",  32'(rv_n[0] - r0), 32'd2);
    chk("b2b_cmd_valid", 32'(cv_n[0] - c0), 32'd2);
    chk("b2b_errors",    32'(ce_n[0] + fe_n[0] + pe_n[0]), 32'(e0));
    chk("b2b_turn_first",  32'(turn_log[ls]), 32'd1);
    chk("b2b_turn_second", 32'(turn_log[ls + 1]), 32'd0);
    chk("b2b_rx_data", 32'(rdat[0]), 32'h4C);

    // SPEED_W=2: saturation and non-command byte
    frame_check(1, 8'h39, BITC_FAST, 1'b0, 1'b0, "sat9");
    frame_check(1, 8'h78, BITC_FAST, 1'b0, 1'b0, "cmd_x");

    // 2-tick low glitch in idle
    s0 = rv_n[1] + fe_n[1] + pe_n[1] + cv_n[1] + ce_n[1];
    rxl[1] = 1'b0;
    tick_wait(8);
    rxl[1] = 1'b1;
    tick_wait(2 * BITC_FAST);
    chk("glitch_pulses", 32'(rv_n[1] + fe_n[1] + pe_n[1] + cv_n[1] + ce_n[1] - s0), 32'd0);
    frame_check(1, 8'h72, BITC_FAST, 1'b0, 1'b0, "post_glitch");

    // Stop bit low, line held low for 3 bit times
    r0 = rv_n[1]; s0 = fe_n[1]; e0 = pe_n[1] + cv_n[1] + ce_n[1];
    send(1, 8'($urandom), BITC_FAST, 1'b0, 1'b0, 1'b0);
    tick_wait(2 * BITC_FAST);
    rxl[1] = 1'b1;
    tick_wait(BITC_FAST);
    chk("break_frame_err", 32'(fe_n[1] - s0), 32'd1);
    chk("break_rx_valid",  32'(rv_n[1] - r0), 32'd0);
    chk("break_other",     32'(pe_n[1] + cv_n[1] + ce_n[1] - e0), 32'd0);
    chk("break_rx_data",   32'(rdat[1]), 32'(exp_data[1]));
    frame_check(1, 8'h31, BITC_FAST, 1'b0, 1'b0, "post_break");

    for (int k = 0; k < 12; k++) frame_check(1, rnd_byte(), BITC_FAST, 1'b0, 1'b0, "s2_rand");

    // Even parity: wrong then right parity on '1'
    frame_check(2, 8'h31, BITC_FAST, 1'b1, 1'b1, "par_wrong");
    frame_check(2, 8'h31, BITC_FAST, 1'b1, 1'b0, "par_right");
    for (int k = 0; k < 10; k++) begin
      b = rnd_byte();
      frame_check(2, b, BITC_FAST, 1'b1, 1'($urandom_range(0, 1)), "par_rand");
    end

    // Reset in the middle of the data bits
    drive_bit(1, 1'b0, BITC_FAST);
    drive_bit(1, 1'b1, BITC_FAST);
    drive_bit(1, 1'b0, BITC_FAST);
    drive_bit(1, 1'b1, BITC_FAST);
    rxl[1] = 1'b1;
    reset  = 1'b1;
    tick_wait(3);
    reset  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_data[i] = '0; exp_speed[i] = 0; exp_turn[i] = 1'b0;
    end
    tick_wait(1);
    check_zero("midreset");
    s0 = rv_n[1] + fe_n[1] + pe_n[1] + cv_n[1] + ce_n[1];
    tick_wait(4 * BITC_FAST);
    chk("midreset_pulses", 32'(rv_n[1] + fe_n[1] + pe_n[1] + cv_n[1] + ce_n[1] - s0), 32'd0);
    frame_check(1, 8'h32, BITC_FAST, 1'b0, 1'b0, "post_reset");

    chk("pulse_overlap", 32'(overlap), 32'd0);
    chk("decode_latency", 32'(bad_lat), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
